// File: rtl/prio_encoder_pipe.sv
// Registered N-input priority encoder with a one-deep valid/ready output stage.
// Optional round-robin arbitration is compiled in when PRIO_ENC_RR_EN is defined.
module prio_encoder_pipe #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  input  logic             mode_i,
  output logic             enc_valid_o,
  input  logic             enc_ready_i,
  output logic [IDX_W-1:0] enc_idx_o,
  output logic [N-1:0]     enc_onehot_o
);

  function automatic logic [IDX_W-1:0] lowest_set(input logic [N-1:0] v);
    lowest_set = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (v[i-1]) lowest_set = IDX_W'(i - 1);
    end
  endfunction

  logic             cap;
  logic             any_req;
  logic [IDX_W-1:0] win;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     onehot_q, onehot_d;

  assign cap     = !valid_q || enc_ready_i;
  assign any_req = |req_i;

`ifdef PRIO_ENC_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     hi_req;

  // Requests at or above ptr; when none remain the search wraps to the whole vector.
  assign hi_req = req_i & ~((N'(1) << ptr_q) - N'(1));
  assign win    = (mode_i && (|hi_req)) ? lowest_set(hi_req) : lowest_set(req_i);

  always_comb begin
    ptr_d = ptr_q;
    if (cap && any_req && mode_i) begin
      ptr_d = (win == IDX_W'(N - 1)) ? '0 : win + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  logic unused_mode;

  assign unused_mode = mode_i;
  assign win         = lowest_set(req_i);
`endif

  always_comb begin
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    if (cap) begin
      valid_d  = any_req;
      idx_d    = any_req ? win : '0;
      onehot_d = any_req ? (N'(1) << win) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
    end else begin
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
    end
  end

  assign enc_valid_o  = valid_q;
  assign enc_idx_o    = idx_q;
  assign enc_onehot_o = onehot_q;

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Bench for prio_encoder_pipe: N=8 and N=5 instances against a circular-scan reference model.
module tb_prio_encoder_pipe;

`ifdef PRIO_ENC_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req8 = '0;
  logic [4:0] req5 = '0;
  logic       mode = 1'b0;
  logic       ready = 1'b0;

  logic       v8, v5;
  logic [2:0] idx8, idx5;
  logic [7:0] oh8;
  logic [4:0] oh5;

  int checks = 0;
  int failures = 0;

  bit m_v [2];
  int m_idx [2];
  int m_ptr [2];

  always #5 clk = ~clk;

  prio_encoder_pipe #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req_i(req8), .mode_i(mode),
    .enc_valid_o(v8), .enc_ready_i(ready), .enc_idx_o(idx8), .enc_onehot_o(oh8)
  );

  prio_encoder_pipe #(.N(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .req_i(req5), .mode_i(mode),
    .enc_valid_o(v5), .enc_ready_i(ready), .enc_idx_o(idx5), .enc_onehot_o(oh5)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Scan n positions circularly starting at the pointer (or at 0 in fixed mode).
  function automatic int pick(input logic [63:0] r, input int n, input int p, input bit rr);
    int start;
    start = rr ? p : 0;
    for (int k = 0; k < n; k++) begin
      int j;
      j = (start + k) % n;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_edge(input int u, input logic [63:0] r, input int n);
    int w;
    if (!m_v[u] || ready) begin
      w = pick(r, n, m_ptr[u], RR && mode);
      if (w < 0) begin
        m_v[u] = 1'b0;
        m_idx[u] = 0;
      end else begin
        m_v[u] = 1'b1;
        m_idx[u] = w;
        if (RR && mode) m_ptr[u] = (w + 1) % n;
      end
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_v[u] = 1'b0;
      m_idx[u] = 0;
      m_ptr[u] = 0;
    end
  endtask

  task automatic check_outs();
    chk("v8", 64'(v8), 64'(m_v[0]));
    chk("idx8", 64'(idx8), 64'(m_idx[0]));
    chk("oh8", 64'(oh8), m_v[0] ? (64'(1) << m_idx[0]) : 64'(0));
    chk("v5", 64'(v5), 64'(m_v[1]));
    chk("idx5", 64'(idx5), 64'(m_idx[1]));
    chk("oh5", 64'(oh5), m_v[1] ? (64'(1) << m_idx[1]) : 64'(0));
    chk("idx5_range", 64'(idx5 <= 3'd4), 64'(1));
  endtask

  task automatic step(input logic [7:0] r8, input logic [4:0] r5, input bit md, input bit rd);
    @(negedge clk);
    req8 = r8;
    req5 = r5;
    mode = md;
    ready = rd;
    @(posedge clk);
    model_edge(0, 64'(r8), 8);
    model_edge(1, 64'(r5), 5);
    #1;
    check_outs();
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_v", 64'(v8), 64'(0));
    chk("rst_idx", 64'(idx8), 64'(0));
    chk("rst_oh", 64'(oh8), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed priority basic
    step(8'hA0, 5'h0C, 1'b0, 1'b1);
    chk("a0_idx", 64'(idx8), 64'(5));
    chk("a0_oh", 64'(oh8), 64'h20);

    // Backpressure: result holds while ready is low
    step(8'h06, 5'h06, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(8'h80, 5'h10, 1'b0, 1'b0);
      chk("bp_idx", 64'(idx8), 64'(1));
      chk("bp_oh", 64'(oh8), 64'h02);
    end
    step(8'h80, 5'h10, 1'b0, 1'b1);
    chk("bp_rel_idx", 64'(idx8), 64'(7));

    // Empty capture
    step(8'h00, 5'h00, 1'b0, 1'b1);
    chk("empty_v", 64'(v8), 64'(0));
    chk("empty_oh", 64'(oh8), 64'(0));

    // Round-robin sweep from ptr=0 (reset just above keeps ptr at 0)
    for (int k = 0; k < 9; k++) begin
      step(8'hFF, 5'h11, 1'b1, 1'b1);
      chk("rr_seq8", 64'(idx8), RR ? 64'(k % 8) : 64'(0));
      chk("rr_seq5", 64'(idx5), RR ? 64'((k % 2) * 4) : 64'(0));
    end

    // Wrap: grant 5 leaves ptr at 6, then 0x21 gives 0 then 5
    step(8'h20, 5'h11, 1'b1, 1'b1);
    chk("wrap_g5", 64'(idx8), 64'(5));
    step(8'h21, 5'h11, 1'b1, 1'b1);
    chk("wrap_g0", 64'(idx8), 64'(0));
    step(8'h21, 5'h11, 1'b1, 1'b1);
    chk("wrap_g5b", 64'(idx8), RR ? 64'(5) : 64'(0));
    for (int k = 0; k < 3; k++) begin
      step(8'h21, 5'h11, 1'b0, 1'b1);
      chk("fixed_g0", 64'(idx8), 64'(0));
    end
    step(8'hFF, 5'h1F, 1'b1, 1'b1);
    chk("ptr_frozen", 64'(idx8), RR ? 64'(6) : 64'(0));

    // Reset during a stall, with a nonzero pointer
    step(8'h10, 5'h08, 1'b1, 1'b1);
    step(8'h08, 5'h01, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rstm_v8", 64'(v8), 64'(0));
    chk("rstm_idx8", 64'(idx8), 64'(0));
    chk("rstm_oh8", 64'(oh8), 64'(0));
    chk("rstm_v5", 64'(v5), 64'(0));
    chk("rstm_oh5", 64'(oh5), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step(8'hFF, 5'h1F, 1'b1, 1'b1);
    chk("post_rst_g0", 64'(idx8), 64'(0));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r8;
      logic [4:0] r5;
      r8 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      r5 = ($urandom_range(0, 7) == 0) ? 5'h00 : 5'($urandom);
      step(r8, r5, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
